// File: rtl/resp_misr_collector.sv
// Response compaction MISR for the two-bit adder/multiplier netlist: folds {m1,m0,h1,h0} per handshake.
// Optional expected-signature comparator enabled by defining RESP_EXPECT_CHK_EN.
module resp_misr_collector #(
  parameter int                SIG_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED  = 16'hFFFF,
  parameter int                CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             h0,
  input  logic             h1,
  input  logic             m0,
  input  logic             m1,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
`ifdef RESP_EXPECT_CHK_EN
  input  logic [SIG_W-1:0] exp_sig,
  output logic             pass,
`endif
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_n;
  logic [SIG_W-1:0]   sig_r;
  logic [SIG_W-1:0]   sig_n;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_n;
  logic [CNT_W-1:0]   target_r;
  logic [CNT_W-1:0]   target_n;
  logic               busy_r;
  logic               ready_r;
  logic               done_r;
  logic               start_acc_s;
  logic               accept_s;
  logic [3:0]         vec_s;

  // One Galois MISR step: shift, conditional tap feedback, then inject the response nibble.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                 input logic [3:0]       vec);
    logic [SIG_W-1:0] nxt;
    nxt = {cur[SIG_W-2:0], 1'b0};
    if (cur[SIG_W-1]) begin
      nxt = nxt ^ POLY;
    end else begin
      nxt = nxt;
    end
    misr_step = nxt ^ {{(SIG_W-4){1'b0}}, vec};
  endfunction

  assign vec_s       = {m1, m0, h1, h0};
  assign start_acc_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign accept_s    = in_valid && (state_r == RUN);

  // Next-state, signature and counter update.
  always_comb begin
    state_n  = state_r;
    sig_n    = sig_r;
    cnt_n    = cnt_r;
    target_n = target_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_acc_s) begin
          sig_n    = SEED;
          cnt_n    = {CNT_W{1'b0}};
          target_n = n_vectors;
          if (n_vectors == {CNT_W{1'b0}}) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
          end
        end else begin
          state_n = state_r;
        end
      end
      RUN: begin
        if (accept_s) begin
          sig_n = misr_step(sig_r, vec_s);
          cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          // The latched count is nonzero here, so cnt_n reaches it before it could wrap.
          if (cnt_n == target_r) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
          end
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      sig_r    <= SEED;
      cnt_r    <= {CNT_W{1'b0}};
      target_r <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      sig_r    <= sig_n;
      cnt_r    <= cnt_n;
      target_r <= target_n;
      busy_r   <= (state_n == RUN);
      ready_r  <= (state_n == RUN);
      done_r   <= (state_n == DONE);
    end
  end

  assign busy      = busy_r;
  assign in_ready  = ready_r;
  assign done      = done_r;
  assign signature = sig_r;
  assign vec_count = cnt_r;

`ifdef RESP_EXPECT_CHK_EN
  logic pass_r;
  logic pass_n;
  logic enter_done_s;

  // A restart with a zero count re-enters DONE even though the state code does not change.
  assign enter_done_s = (state_n == DONE) && ((state_r == RUN) || start_acc_s);

  // Verdict is captured once on DONE entry and cleared by an accepted start.
  always_comb begin
    pass_n = pass_r;
    if (enter_done_s) begin
      pass_n = (sig_n == exp_sig);
    end else if (start_acc_s) begin
      pass_n = 1'b0;
    end else begin
      pass_n = pass_r;
    end
  end

  // Verdict register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_r <= 1'b0;
    end else begin
      pass_r <= pass_n;
    end
  end

  assign pass = pass_r;
`endif

endmodule

// File: tb/tb_resp_misr_collector.sv
// Self-checking bench for resp_misr_collector: directed cases plus randomized runs against a reference model.
module tb_resp_misr_collector;

  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  n_vectors;
  logic        in_valid;
  logic        in_ready;
  logic        h0, h1, m0, m1;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [7:0]  vec_count;
  logic [15:0] exp_sig;
  logic        pass_bit;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: abstract run status, not the RTL state encoding.
  logic [15:0] m_sig;
  int          m_cnt;
  int          m_target;
  bit          m_busy;
  bit          m_done;
  bit          m_pass;

  logic [3:0]  vecs [0:254];

  always #5 clk = ~clk;

  resp_misr_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_vectors (n_vectors),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .h0        (h0),
    .h1        (h1),
    .m0        (m0),
    .m1        (m1),
    .busy      (busy),
    .done      (done),
    .signature (signature),
`ifdef RESP_EXPECT_CHK_EN
    .exp_sig   (exp_sig),
    .pass      (pass_bit),
`endif
    .vec_count (vec_count)
  );

`ifndef RESP_EXPECT_CHK_EN
  assign pass_bit = 1'b0;
`endif

  // Signature arithmetic: doubling modulo 2^16, polynomial reduction on overflow, XOR in the response.
  function automatic logic [15:0] fold(input logic [15:0] s, input logic [3:0] v);
    int unsigned x;
    x = (32'(s) * 32'd2) % 32'd65536;
    if (s >= 16'h8000) x = x ^ 32'(POLY);
    x = x ^ 32'(v);
    return x[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, "/signature"}, 32'(signature), 32'(m_sig));
    check({ctx, "/vec_count"}, 32'(vec_count), 32'(m_cnt));
    check({ctx, "/busy"},      32'(busy),      32'(m_busy));
    check({ctx, "/in_ready"},  32'(in_ready),  32'(m_busy));
    check({ctx, "/done"},      32'(done),      32'(m_done));
`ifdef RESP_EXPECT_CHK_EN
    check({ctx, "/pass"},      32'(pass_bit),  32'(m_pass));
`endif
  endtask

  task automatic model_reset();
    m_sig = SEED; m_cnt = 0; m_target = 0;
    m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, take the edge, compare everything.
  task automatic cyc(input string ctx, input bit st, input int n, input bit v, input logic [3:0] vec);
    start = st; n_vectors = n[7:0]; in_valid = v; {m1, m0, h1, h0} = vec;
    if (m_busy) begin
      if (v) begin
        m_sig = fold(m_sig, vec);
        m_cnt++;
        if (m_cnt == m_target) begin
          m_busy = 1'b0; m_done = 1'b1; m_pass = (m_sig == exp_sig);
        end
      end
    end else if (st) begin
      m_sig = SEED; m_cnt = 0; m_target = n;
      m_busy = (n != 0); m_done = (n == 0);
      m_pass = (n == 0) && (SEED == exp_sig);
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    int budget;
    int n;
    logic [15:0] golden;

    rst = 1'b1; start = 1'b0; n_vectors = 8'd0; in_valid = 1'b1;
    {m1, m0, h1, h0} = 4'b1111; exp_sig = 16'hEFDF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst/signature", 32'(signature), 32'h0000_FFFF);
      check("rst/vec_count", 32'(vec_count), 32'd0);
      check("rst/in_ready",  32'(in_ready),  32'd0);
      check("rst/busy",      32'(busy),      32'd0);
      check("rst/done",      32'(done),      32'd0);
`ifdef RESP_EXPECT_CHK_EN
      check("rst/pass",      32'(pass_bit),  32'd0);
`endif
    end
    rst = 1'b0; in_valid = 1'b0;
    model_reset();

    // Single zero vector, matching expected signature.
    cyc("n1_start", 1'b1, 1, 1'b0, 4'b0000);
    cyc("n1_acc",   1'b0, 0, 1'b1, 4'b0000);
    check("n1_const_sig", 32'(signature), 32'h0000_EFDF);
    cyc("n1_hold",  1'b0, 0, 1'b1, 4'b0101);

    // Same run with a mismatching expectation.
    exp_sig = 16'h0000;
    cyc("n1b_start", 1'b1, 1, 1'b0, 4'b0000);
    cyc("n1b_acc",   1'b0, 0, 1'b1, 4'b0000);

    // Two vectors, first 0101; restart also clears any verdict.
    exp_sig = 16'hEFDF;
    cyc("n2a_start", 1'b1, 2, 1'b0, 4'b0000);
    cyc("n2a_v0",    1'b0, 0, 1'b1, 4'b0101);
    check("n2a_const_sig0", 32'(signature), 32'h0000_EFDA);
    cyc("n2a_v1",    1'b0, 0, 1'b1, 4'b0000);

    // Two zero vectors.
    cyc("n2b_start", 1'b1, 2, 1'b0, 4'b0000);
    cyc("n2b_v0",    1'b0, 0, 1'b1, 4'b0000);
    check("n2b_const_sig0", 32'(signature), 32'h0000_EFDF);
    cyc("n2b_v1",    1'b0, 0, 1'b1, 4'b0000);
    check("n2b_const_sig1", 32'(signature), 32'h0000_CF9F);

    // Toggling valid, plus a start during RUN that must be ignored.
    cyc("n3_start", 1'b1, 3, 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      cyc("n3_step", (i == 1), 0, (i % 2 == 0), 4'($urandom_range(0, 15)));
    end

    // Zero-length run.
    exp_sig = SEED;
    cyc("n0_start", 1'b1, 0, 1'b0, 4'b0000);
    cyc("n0_hold",  1'b0, 0, 1'b1, 4'b1010);

    // Reset in the middle of a run.
    cyc("mid_start", 1'b1, 5, 1'b0, 4'b0000);
    cyc("mid_v0",    1'b0, 0, 1'b1, 4'($urandom_range(0, 15)));
    cyc("mid_v1",    1'b0, 0, 1'b1, 4'($urandom_range(0, 15)));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_all("mid_rst");
    cyc("idle_valid", 1'b0, 0, 1'b1, 4'b1111);

    // Randomized runs with random valid gaps and spurious starts.
    for (int r = 0; r < 20; r++) begin
      exp_sig = 16'($urandom);
      n = $urandom_range(1, 12);
      cyc("rnd_start", 1'b1, n, 1'b0, 4'b0000);
      budget = 200;
      while (m_busy && budget > 0) begin
        cyc("rnd_step", ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
            ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
        budget--;
      end
      check("rnd_budget", 32'(budget > 0), 32'd1);
      cyc("rnd_idle", 1'b0, 0, 1'b1, 4'($urandom_range(0, 15)));
    end

    // Maximum count at full throughput, expectation precomputed from the vector list.
    golden = SEED;
    for (int i = 0; i < 255; i++) begin
      vecs[i] = 4'($urandom_range(0, 15));
      golden = fold(golden, vecs[i]);
    end
    exp_sig = golden;
    cyc("max_start", 1'b1, 255, 1'b0, 4'b0000);
    for (int i = 0; i < 255; i++) begin
      cyc("max_step", 1'b0, 0, 1'b1, vecs[i]);
    end
    check("max_count", 32'(vec_count), 32'd255);
    check("max_done",  32'(done),      32'd1);
    check("max_sig",   32'(signature), 32'(golden));
    cyc("max_hold", 1'b0, 0, 1'b1, 4'b0011);
    cyc("max_restart", 1'b1, 1, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/resp_misr_collector.md
# resp_misr_collector

- Downstream response-compaction stage for the two-bit adder/multiplier netlist.
- Accepts one response vector per handshake from the netlist outputs `h0`, `h1`, `m0`, `m1` and folds it into a multiple-input signature register (MISR).
- After a programmed number of vectors, presents the final signature for golden-vs-revised equivalence comparison.

## Interface

Parameters:
- `SIG_W`, 16: signature width; must be at least 4.
- `POLY`, 16'h1021: Galois feedback taps, SIG_W bits.
- `SEED`, 16'hFFFF: signature value loaded on reset and on start.
- `CNT_W`, 8: width of the vector counter and of `n_vectors`.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a run; sampled in IDLE and DONE only.
- `n_vectors`, input, CNT_W: vectors per run; sampled when `start` is accepted.
- `in_valid`, input, 1: upstream response vector is valid.
- `in_ready`, output, 1: collector can accept a vector.
- `h0`, `h1`, `m0`, `m1`, input, 1 each: netlist response bits.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in DONE.
- `signature`, output, SIG_W: current MISR value.
- `vec_count`, output, CNT_W: vectors accepted in the current run.

## Operation

- States: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - Load `signature`=SEED and `vec_count`=0.
  - Latch `n_vectors` internally.
  - Next state is RUN, or DONE if the latched value is 0.
- RUN:
  - `in_ready`=1.
  - A vector is accepted on any cycle with `in_valid` && `in_ready`.
- Accept update:
  - fb = signature[SIG_W-1].
  - signature' = (signature<<1) ^ (fb ? POLY : 0) ^ zero-extended {m1,m0,h1,h0}.
  - `vec_count` increments by 1.
- When the accept makes `vec_count` equal to the latched count, the next state is DONE.
- DONE:
  - `done`=1.
  - `signature` and `vec_count` hold.
  - `start` restarts exactly as in IDLE; with no `start`, DONE holds indefinitely.
- `start` during RUN is ignored; the latched count does not change.
- `in_valid` outside RUN is ignored; no state change.
- Latched count 255 (CNT_W=8) is legal. The counter never wraps inside a run.

## Timing

- Reset values:
  - state IDLE
  - `signature`=SEED
  - `vec_count`=0
  - `in_ready`=0, `busy`=0, `done`=0
- `rst` overrides everything. Reset asserted mid-run discards partial results and returns to IDLE on the next edge.
- `start` is sampled in cycle t; `busy`/`in_ready` are high from t+1.
- Accept in cycle t: the updated `signature` and `vec_count` are visible from t+1.
- Final accept in cycle t: `done`=1 and `in_ready`=0 from t+1. No extra latency.
- `n_vectors`=0: `done`=1 at t+1 with `signature`=SEED.
- Throughput: one vector per cycle with `in_valid` held high.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Configuration

`RESP_EXPECT_CHK_EN`:
- Defined:
  - Adds input `exp_sig` (SIG_W) and output `pass` (1).
  - `pass` is registered: it is set on entry to DONE iff the final `signature` equals `exp_sig` sampled on that cycle.
  - `pass` is cleared on reset and on `start`, and holds during DONE.
- Undefined: neither port exists, and no comparator logic is built.

## Test plan

- Reset with `in_valid`=1 and `start`=0 -> `signature`=16'hFFFF, `vec_count`=0, `in_ready`=`busy`=`done`=0 across 5 cycles.
- `start` with `n_vectors`=1, one vector {m1,m0,h1,h0}=4'b0000 -> `signature`=16'hEFDF, `done`=1 the next cycle.
- `n_vectors`=2, two vectors of 0000 -> `signature` 16'hEFDF then 16'hCF9F, `vec_count`=2, `done`=1. With the first vector 0101 -> 16'hEFDA after the first accept.
- `n_vectors`=3 with `in_valid` toggling every other cycle -> only handshaked vectors counted. `done` asserts the cycle after the 3rd accept.
- `n_vectors`=0 -> `done` one cycle after `start`, with `signature`=16'hFFFF. `start` asserted in RUN -> ignored. `rst` mid-run -> IDLE and SEED next cycle.
- `RESP_EXPECT_CHK_EN` with `exp_sig`=16'hEFDF, one 0000 vector -> `pass`=1. With `exp_sig`=16'h0000 -> `pass`=0. `pass` cleared on the next `start`.
